mips_mem_access_unit: RTL

- Initiator side of the data-memory interface: turns load/store requests from the execute stage into data-memory cycles.
- Drives the word-indexed memory port `mem_address`, `write_data`, `sig_mem_read`, `sig_mem_write` and samples `read_data`, which is combinational.
- Supports byte, half-word and word access on word-only memory: sub-word loads are extracted and extended, sub-word stores use read-modify-write.
- Checks alignment and range, then returns a one-cycle response to the pipeline.

---
 rtl/mips_mem_pkg.sv | 7 +
 rtl/mips_lane_align.sv | 34 +++
 rtl/mips_mem_access_unit.sv | 93 +++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: access-size and FSM state encodings shared by the memory access unit
package mips_mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RESP} state_t;
endpackage

// File: rtl/mips_lane_align.sv
// mips_lane_align: byte-lane extract/extend for loads, lane merge for stores, alignment check
// Ports: word (memory word), offset (byte offset in word), size, is_unsigned, wdata (right-justified store data)
//        -> rdata (extended load value), merged (word with target lanes replaced), misaligned (incl. illegal size)
module mips_lane_align
  import mips_mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1
) (
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged,
  output logic        misaligned
);
  logic [4:0]  shift;
  logic [31:0] lane;
  logic [31:0] mask;
  always_comb begin
    // big-endian puts offset 0 in the top lane, so the shift counts down from the top
    shift = size == SZ_WORD ? 5'd0
          : BIG_ENDIAN ? (size == SZ_BYTE ? 5'd24 : 5'd16) - {offset, 3'b000}
          : {offset, 3'b000};
    lane = word >> shift;
    mask = (size == SZ_BYTE ? 32'h0000_00ff : 32'h0000_ffff) << shift;
    rdata = size == SZ_BYTE ? {{24{lane[7] & ~is_unsigned}}, lane[7:0]}
          : size == SZ_HALF ? {{16{lane[15] & ~is_unsigned}}, lane[15:0]}
          : word;
    merged = size == SZ_WORD ? wdata : (word & ~mask) | ((wdata << shift) & mask);
    misaligned = size == 2'd3 || (size == SZ_HALF && offset[0]) || (size == SZ_WORD && offset != 2'd0);
  end
endmodule

// File: rtl/mips_mem_access_unit.sv
// mips_mem_access_unit: turns execute-stage load/store requests into word-memory cycles
// Ports: clk, reset (sync, active-high); req_valid/req_ready/req_write/req_size/req_unsigned/req_addr/req_wdata
//        request side; resp_valid/resp_rdata/resp_error one-cycle response; mem_address/write_data/
//        sig_mem_read/sig_mem_write registered memory strobes; read_data combinational memory word.
module mips_mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WORDS = 256,
  parameter bit BIG_ENDIAN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] write_data,
  output logic        sig_mem_read,
  output logic        sig_mem_write,
  input  logic [31:0] read_data
);
  state_t state, state_n;
  logic [1:0]  offset, size, sel_offset, sel_size;
  logic        is_unsigned, write, accept, error, misaligned;
  logic [31:0] wdata, load_data, merged;
  assign req_ready = state == ST_IDLE;
  assign accept = req_valid && req_ready;
  // while idle the aligner checks the incoming request; afterwards it works on the latched one
  assign sel_offset = req_ready ? req_addr[1:0] : offset;
  assign sel_size = req_ready ? req_size : size;
  assign error = misaligned || {2'b00, req_addr[31:2]} >= 32'(ADDR_WORDS);
  mips_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .word(read_data),
    .offset(sel_offset),
    .size(sel_size),
    .is_unsigned(is_unsigned),
    .wdata(wdata),
    .rdata(load_data),
    .merged(merged),
    .misaligned(misaligned)
  );
  always_comb begin
    state_n = state;
    state_n = state == ST_IDLE ? (!accept ? ST_IDLE
                                : error ? ST_RESP
                                : (req_write && req_size == SZ_WORD) ? ST_WRITE : ST_READ)
            : state == ST_READ ? (write ? ST_WRITE : ST_RESP)
            : state == ST_WRITE ? ST_RESP
            : ST_IDLE;
  end
  // memory-side outputs are registered from the next state so strobes are clean for the whole cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      offset <= 2'd0;
      size <= 2'd0;
      is_unsigned <= 1'b0;
      write <= 1'b0;
      wdata <= 32'd0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= 32'd0;
      mem_address <= 32'd0;
      write_data <= 32'd0;
      sig_mem_read <= 1'b0;
      sig_mem_write <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        offset <= req_addr[1:0];
        size <= req_size;
        is_unsigned <= req_unsigned;
        write <= req_write;
        wdata <= req_wdata;
        mem_address <= {2'b00, req_addr[31:2]};
      end
      sig_mem_read <= state_n == ST_READ;
      sig_mem_write <= state_n == ST_WRITE;
      resp_valid <= state_n == ST_RESP;
      resp_error <= state == ST_IDLE && state_n == ST_RESP;
      resp_rdata <= (state == ST_READ && state_n == ST_RESP) ? load_data : 32'd0;
      // the read word is merged on the same edge it is captured, straight from read_data
      if (state_n == ST_WRITE) write_data <= state == ST_IDLE ? req_wdata : merged;
    end
  end
endmodule
